// File: rtl/wordcell_pkg.sv
// ============================================================================
// Module   : wordcell_pkg
// Purpose  : Shared word width and row-operation encoding for the bitcell array.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wordcell_pkg;

    localparam int   WORD_W   = 8;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/word_cell_bitcell.sv
// ============================================================================
// Module   : bitcell
// Purpose  : One storage bit with a write port and an AND-gated read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bitcell (
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  logic re,
    input  logic d,
    output logic q,
    output logic rd
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (we) begin
            bit_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q  = bit_q;
    // Gating with re keeps the bit at 0 when idle so rows can be OR-merged.
    assign rd = re & bit_q;

endmodule

`default_nettype wire

// File: rtl/word_cell.sv
// ============================================================================
// Module   : word_cell
// Purpose  : One WIDTH-bit row of bitcells sharing a row select and op line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_cell
    import wordcell_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op,
    input  logic             sel_x,
    input  logic [WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0] out_bus,
    output logic [WIDTH-1:0] stored_value
);

    logic w_we;
    logic w_re;

    // Decoded once per row; the two enables are mutually exclusive.
    assign w_we = sel_x & (op == OP_WRITE);
    assign w_re = sel_x & (op == OP_READ);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bitcell u_bitcell (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_we),
            .re    (w_re),
            .d     (in_bus[i]),
            .q     (stored_value[i]),
            .rd    (out_bus[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_word_cell.sv
// ============================================================================
// Module   : tb_word_cell
// Purpose  : Randomised and directed scoreboard bench for word_cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_word_cell;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op;
    logic         sel_x;
    logic [W-1:0] in_bus;
    logic [W-1:0] out_bus;
    logic [W-1:0] stored_value;

    word_cell #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .sel_x        (sel_x),
        .in_bus       (in_bus),
        .out_bus      (out_bus),
        .stored_value (stored_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] exp_sv;
        logic [W-1:0] exp_ob;
    } sb_t;

    sb_t          sb_q[$];
    event         ev_chk;
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] model;

    // Monitor: pops expectations whenever the stimulus presents a settled output.
    initial begin
        sb_t e;
        forever begin
            @(ev_chk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if (stored_value !== e.exp_sv || out_bus !== e.exp_ob) begin
                    n_err++;
                    $display("FAIL %s: stored_value=%h out_bus=%h, required stored_value=%h out_bus=%h",
                             e.name, stored_value, out_bus, e.exp_sv, e.exp_ob);
                end
            end
        end
    end

    task automatic drive(input logic s, input logic o, input logic [W-1:0] d);
        sel_x  = s;
        op     = o;
        in_bus = d;
    endtask

    task automatic expect_now(input string nm);
        sb_t e;
        e.name   = nm;
        e.exp_sv = model;
        e.exp_ob = (sel_x === 1'b1 && op === 1'b0) ? model : '0;
        sb_q.push_back(e);
        ->ev_chk;
        #1;
    endtask

    task automatic tick(input string nm);
        @(posedge clk);
        if (rst_n && sel_x && op) model = in_bus;
        #1;
        expect_now(nm);
    endtask

    task automatic go_mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        model = '0;
        drive(1'b0, 1'b0, '0);
        #12;
        expect_now("reset_init");
        rst_n = 1'b1;
        go_mid();

        // Put data in, then prove an edge-free reset pulse clears it.
        drive(1'b1, 1'b1, 8'hA7);
        tick("pre_write");
        drive(1'b1, 1'b0, 8'h00);
        go_mid();
        expect_now("pre_read");
        rst_n = 1'b0;
        model = '0;
        #1;
        expect_now("async_reset");
        rst_n = 1'b1;
        #1;
        expect_now("after_reset_pulse");

        go_mid();
        drive(1'b0, 1'b1, 8'h55);
        tick("desel_write_op1");
        drive(1'b0, 1'b0, 8'h55);
        tick("desel_write_op0");

        go_mid();
        drive(1'b1, 1'b1, 8'h55);
        expect_now("write_cycle_out0");
        tick("write_55");
        go_mid();
        drive(1'b1, 1'b0, 8'h00);
        expect_now("read_55");

        drive(1'b0, 1'b0, 8'h00);
        expect_now("disable_hold");
        go_mid();
        drive(1'b1, 1'b1, 8'hCC);
        tick("write_CC");
        go_mid();
        drive(1'b1, 1'b0, 8'h00);
        expect_now("read_CC");

        for (int i = 0; i < 4; i++) begin
            in_bus = W'($urandom);
            tick("read_in_toggle");
        end

        // Reset asserted mid-write and held across one edge.
        go_mid();
        drive(1'b1, 1'b1, 8'hFF);
        #1;
        rst_n = 1'b0;
        model = '0;
        #1;
        expect_now("reset_mid_write");
        tick("reset_edge_no_write");
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 8'hFF);
        expect_now("reset_released");
        tick("after_reset_release");

        // Randomised traffic, including mid-cycle mode changes and reset pulses.
        for (int i = 0; i < 300; i++) begin
            go_mid();
            drive(1'($urandom), 1'($urandom), W'($urandom));
            expect_now("rand_a");
            if ($urandom_range(0, 3) == 0) begin
                drive(1'($urandom), 1'($urandom), W'($urandom));
                expect_now("rand_b");
            end
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                model = '0;
                #1;
                expect_now("rand_reset");
                rst_n = 1'b1;
                #1;
            end
            tick("rand_edge");
        end

        #5;
        ->ev_chk;
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/word_cell.md
# word_cell

One WIDTH-bit storage word of the bitcell memory array: a row of bitcells that share one row-select line (`sel_x`) and one operation line (`op`). When the row is selected, `op` chooses the operation. A write captures `in_bus` on the clock edge. A read drives the stored word onto `out_bus`. The raw stored contents are always visible on `stored_value` for debug and observation. The column/row decoder instantiates one `word_cell` per row and combines the `out_bus` outputs of all rows by OR.

## Interface
- `WIDTH`, default 8: number of bitcells in the word, and the width of `in_bus`, `out_bus` and `stored_value`.
- `clk`  input  1  single clock for the block; all state changes happen on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low; clears every bitcell to 0.
- `op`  input  1  operation select: 1 = write, 0 = read. Only meaningful while `sel_x` = 1.
- `sel_x`  input  1  row select: 1 = this word takes part in the operation.
- `in_bus`  input  WIDTH  write data.
- `out_bus`  output  WIDTH  read data; all zeros whenever the word is not being read.
- `stored_value`  output  WIDTH  current contents of the word, unconditionally.

## Operation
- Modes are decoded from `sel_x` and `op`:
  - Idle (`sel_x` = 0, any `op`): contents hold and `out_bus` = 0. `in_bus` is ignored.
  - Read (`sel_x` = 1, `op` = 0): `out_bus` = stored word and contents hold. `in_bus` is ignored.
  - Write (`sel_x` = 1, `op` = 1): on the rising `clk` edge, every bit loads its `in_bus` bit. `out_bus` = 0 for the whole write cycle; the block never reads and writes at the same time.
- Each bitcell is independent. There is no partial-word write; all WIDTH bits load together.
- `stored_value` always equals the stored word, in every mode and during reset.
- Bus-merge rule: `out_bus` is forced to zero when the word is not being read, so the decoder can OR the outputs of many words without tri-states.
- There are no X or Z outputs after reset.

## Timing
- Write latency is 1 cycle. Data present at the rising edge with write mode active appears on `stored_value` right after that edge.
- Read is combinational from the stored state and the `sel_x`/`op` decode. `out_bus` is valid in the same cycle the read mode is applied, with no added register stage.
- Reset behaviour:
  - Asserting `rst_n` low clears the contents to 0 immediately, without waiting for `clk`, so `stored_value` = 0 and `out_bus` = 0.
  - While `rst_n` = 0, writes are ignored.
  - The first write can take effect on the first rising edge after `rst_n` goes high.
- Reset in the middle of a write cycle: reset wins, and the word is 0 after release.
- A change of `in_bus` while not in write mode has no effect at any edge.
- Mode changes between edges: only the value of the `sel_x`/`op` decode at the rising edge decides whether a write happens.

## Structure
- A shared package `wordcell_pkg` holds:
  - the default width constant `WORD_W = 8`;
  - the encoding constants `OP_READ = 1'b0` and `OP_WRITE = 1'b1`.
- The natural sub-module is `bitcell`, one storage bit with these ports: `clk`, `rst_n`, write-enable, read-enable, `d`, `q`, `rd`.
- `word_cell` decodes `sel_x`/`op` once into a write-enable and a read-enable. It then generates WIDTH `bitcell` instances and concatenates their `q` outputs into `stored_value` and their `rd` outputs into `out_bus`.

## Test plan
- Reset: pulse `rst_n` low with no clock edge -> `stored_value` = 0x00 and `out_bus` = 0x00 immediately.
- Deselected write: `op`=1, `sel_x`=0, `in_bus`=0x55, then one edge -> `stored_value` stays 0x00 and `out_bus` = 0x00. Same check with `op`=0.
- Write then read:
  - `op`=1, `sel_x`=1, `in_bus`=0x55, then one edge -> `stored_value` = 0x55 and `out_bus` = 0x00 during the write.
  - Then `op`=0, `sel_x`=1, `in_bus`=0x00 -> `out_bus` = 0x55 combinationally and `stored_value` still 0x55.
- Disable and overwrite:
  - `sel_x`=0 -> `out_bus` = 0x00 and contents still 0x55.
  - Write 0xCC, then read -> `out_bus` = 0xCC and `stored_value` = 0xCC.
- Read during a changing `in_bus`: in read mode, toggle `in_bus` across several edges -> contents and `out_bus` are unchanged.
- Asynchronous reset mid-write: hold write mode with `in_bus` = 0xFF, assert `rst_n` between edges and release it after one edge -> `stored_value` = 0x00 and no write occurred while in reset.
